// File: rtl/prog_loader_if.sv
// Boot-loader bus: start pulse, byte stream in, instruction-memory write port and status out.
// The loader attaches through the slave modport; the boot host / bench uses master.
interface prog_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed little-endian byte stream and writes it
// word by word into instruction memory while holding the CPU in reset.
module prog_loader #(
    parameter int unsigned DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);

    localparam int unsigned IDX_W  = $clog2(DEPTH + 1);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          byte_cnt;
    logic [23:0]         word_lo;

    logic                rx_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                cpu_hold_q;

    logic                xfer_c;
    logic [LEN_W-1:0]    len_c;
    logic                len_bad_c;
    logic                last_word_c;

    assign xfer_c      = bus.rx_valid & rx_ready_q;
    assign len_c       = {bus.rx_data, len[7:0]};
    assign len_bad_c   = (len_c == '0) || (32'(len_c) > 32'(DEPTH));
    assign last_word_c = (LEN_W'(idx) == (len - LEN_W'(1)));

    // Session FSM with all outputs registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            idx         <= '0;
            byte_cnt    <= '0;
            word_lo     <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state      <= LEN_LO;
                        idx        <= '0;
                        byte_cnt   <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cpu_hold_q <= 1'b1;
                    end
                end

                LEN_LO: begin
                    if (xfer_c) begin
                        len[7:0] <= bus.rx_data;
                        state    <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (xfer_c) begin
                        len[15:8] <= bus.rx_data;
                        if (len_bad_c) begin
                            state      <= ERR;
                            error_q    <= 1'b1;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            cpu_hold_q <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: word_lo[7:0]   <= bus.rx_data;
                            2'd1: word_lo[15:8]  <= bus.rx_data;
                            2'd2: word_lo[23:16] <= bus.rx_data;
                            2'd3: begin
                                // Fourth byte goes straight to the write port so WRITE needs no extra cycle.
                                state       <= WRITE;
                                rx_ready_q  <= 1'b0;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= BASE_ADDR + (ADDR_W'(idx) << 2);
                                mem_wdata_q <= {bus.rx_data, word_lo};
                            end
                            default: ;
                        endcase
                    end
                end

                WRITE: begin
                    idx <= idx + IDX_W'(1);
                    if (last_word_c) begin
                        state      <= DONE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        state      <= DATA;
                        rx_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.cpu_hold  = cpu_hold_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 512: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_valid  input  1  byte source has rx_data available.
REQ-007 rx_data  input  8  byte from the serial/boot source.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready).
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  32  word-aligned byte address; bits [1:0] always 0; word index on bits [23:2].
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  sticky: last session completed successfully.
REQ-014 error  output  1  sticky: last session aborted on bad length.
REQ-015 cpu_hold  output  1  holds the processor in reset while 1.

Function
REQ-016 The loader SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-017 Session format: 2 length bytes (word count N, little-endian), then 4*N data bytes; each word little-endian (first byte -> bits [7:0]).
REQ-018 IDLE/DONE/ERR: start=1 -> LEN_LO, clear done, error, word index, byte counter; start ignored in other states.
REQ-019 rx_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA; 0 in all other states.
REQ-020 LEN_LO: on transfer, latch N[7:0] -> LEN_HI. LEN_HI: on transfer, latch N[15:8], then N==0 or N>DEPTH -> ERR, else -> DATA.
REQ-021 DATA: each transfer places the byte into lane byte_cnt and increments byte_cnt (2 bits, wraps); the transfer with byte_cnt==3 -> WRITE.
REQ-022 WRITE lasts exactly one cycle: mem_we=1, mem_addr=BASE_ADDR+4*idx, mem_wdata=assembled word; idx increments; -> DONE if idx was N-1, else -> DATA.
REQ-023 Latency: mem_we asserts in the cycle immediately after the 4th byte of a word is accepted; maximum throughput one word per 5 cycles.
REQ-024 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_wdata hold last values otherwise.
REQ-025 rx_valid=0 in LEN_LO/LEN_HI/DATA stalls indefinitely with no state change; no timeout.
REQ-026 busy=1 in LEN_LO, LEN_HI, DATA, WRITE; 0 otherwise.
REQ-027 DONE: done=1, cpu_hold=0; remains until start or rst.
REQ-028 ERR: error=1, cpu_hold=1, no write issued for the session; remains until start or rst.
REQ-029 cpu_hold SHALL be 1 in every state except DONE.
REQ-030 idx counter SHALL be wide enough for DEPTH (10 bits at default); no write beyond index DEPTH-1 is possible.
REQ-031 Bytes presented while rx_ready=0 SHALL not be consumed.

Reset
REQ-032 rst=1 at a clock edge -> IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1, counters 0.
REQ-033 rst mid-session SHALL abandon the session; no mem_we in the cycle following reset; partially written memory is not restored.
REQ-034 rst has priority over start and over any transfer in the same cycle.

Verification
REQ-035 start; bytes 02 00, 13 00 00 00, 93 00 10 00 with rx_valid=1 -> writes (0x0, 0x00000013), (0x4, 0x00100093); done=1, cpu_hold=0, busy=0.
REQ-036 start; length 00 00 -> ERR, error=1, cpu_hold=1, mem_we never asserted.
REQ-037 start; length 01 02 (N=513) -> ERR; then start; length 01 00, data EF BE AD DE -> write (0x0, 0xDEADBEEF), error=0, done=1.
REQ-038 N=1, rx_valid toggled 0/1 every cycle -> exactly 4 bytes consumed, single mem_we one cycle after 4th transfer, rx_ready=0 during WRITE.
REQ-039 N=512 full load -> last write at mem_addr 0x7FC, 512 mem_we pulses total, done=1.
REQ-040 rst asserted after 2 data bytes of word 0 -> all outputs at reset values next cycle, no write; new session then loads correctly from address 0.
